maxnet_engine: RTL and testbench

- Sequential 4-neuron Maxnet winner-take-all engine; sits directly downstream of the 2-bit neuron-index counter and consumes its count and carry-out.
- Drives the counter's init and enable, uses the count as the neuron index, loads four activations and iterates mutual inhibition until at most one neuron remains nonzero.
- Reports the winner index and value to the top-level controller.

---
 rtl/maxnet_engine.sv | 143 ++++++++++++++
 tb/tb_maxnet_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_engine.sv
// Sequential 4-neuron Maxnet winner-take-all engine. Walks an external 2-bit
// counter through load, sum and update phases until at most one neuron survives.
module maxnet_engine #(
  parameter int DATA_W    = 8,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 8,
  parameter int ITER_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [1:0]        cnt_val,
  input  logic              cnt_co,
  output logic              cnt_init,
  output logic              cnt_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic [DATA_W-1:0] winner_val,
  output logic              no_winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam int SUM_W = DATA_W + 2;

  typedef enum logic [2:0] {IDLE, LOAD, SUM, UPDATE, CHECK, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] a [4];
  logic [DATA_W-1:0] n [4];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  inhib;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] n_cur;
  logic [2:0]        nz;
  logic [1:0]        low_idx;
  logic              found;
  logic              iter_max;

  assign a_sel    = a[cnt_val];
  assign inhib    = (sum - SUM_W'(a_sel)) >> EPS_SHIFT;
  // inhib < a_sel whenever the subtraction is taken, so the truncation is exact
  assign n_cur    = (SUM_W'(a_sel) > inhib) ? a_sel - inhib[DATA_W-1:0] : '0;
  assign iter_max = (iter_count == ITER_W'(MAX_ITER));

  always_comb begin
    nz      = '0;
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (a[i] != '0) begin
        nz = nz + 3'd1;
        if (!found) begin
          low_idx = 2'(i);
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (in_valid && cnt_co) state_nx = CHECK;
      SUM:     if (cnt_co) state_nx = UPDATE;
      UPDATE:  if (cnt_co) state_nx = CHECK;
      CHECK:   state_nx = (nz <= 3'd1 || iter_max) ? DONE : SUM;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset also clears the counter so an aborted run leaves it at 0
  assign cnt_init = !rst || (state == IDLE);
  assign cnt_en   = rst && ((state == LOAD && in_valid) || state == SUM || state == UPDATE);
  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sum        <= '0;
      iter_count <= '0;
      winner     <= '0;
      winner_val <= '0;
      no_winner  <= 1'b0;
      timeout    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        a[i] <= '0;
        n[i] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            iter_count <= '0;
            no_winner  <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) a[cnt_val] <= in_data;
        end
        SUM: begin
          sum <= sum + SUM_W'(a_sel);
        end
        UPDATE: begin
          n[cnt_val] <= n_cur;
          // Last neuron's result is not in the shadow buffer yet; take it directly
          if (cnt_co) begin
            for (int unsigned j = 0; j < 4; j++)
              a[j] <= (2'(j) == cnt_val) ? n_cur : n[j];
            iter_count <= iter_count + 1'b1;
          end
        end
        CHECK: begin
          sum <= '0;
          if (nz == 3'd0) begin
            no_winner  <= 1'b1;
            winner     <= '0;
            winner_val <= '0;
          end else if (nz == 3'd1) begin
            winner     <= low_idx;
            winner_val <= a[low_idx];
          end else if (iter_max) begin
            timeout    <= 1'b1;
            winner     <= low_idx;
            winner_val <= a[low_idx];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_engine.sv
// Directed bench for maxnet_engine with a behavioural neuron-index counter and
// a scoreboard of expected results.
module tb_maxnet_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [1:0] cnt_val;
  logic       cnt_co;
  logic       cnt_init;
  logic       cnt_en;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic [7:0] winner_val;
  logic       no_winner;
  logic       timeout;
  logic [3:0] iter_count;

  typedef struct {
    logic [1:0] w;
    logic [7:0] v;
    logic [3:0] it;
    logic       nw;
    logic       to;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  // 2-bit neuron-index counter the engine drives
  always @(posedge clk) begin
    if (cnt_init)    cnt_val <= 2'd0;
    else if (cnt_en) cnt_val <= cnt_val + 2'd1;
  end
  assign cnt_co = (cnt_val == 2'd3);

  maxnet_engine #(.DATA_W(8), .EPS_SHIFT(2), .MAX_ITER(8), .ITER_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cnt_val(cnt_val), .cnt_co(cnt_co), .cnt_init(cnt_init),
    .cnt_en(cnt_en), .busy(busy), .done(done), .winner(winner),
    .winner_val(winner_val), .no_winner(no_winner), .timeout(timeout),
    .iter_count(iter_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    check("idle_before_start", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_ready", in_ready, 1);
    check("load_cnt0", cnt_val, 0);
  endtask

  task automatic load4(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3, input int gap);
    logic [7:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      if (i == 2 && gap > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          start = (g == 0);
          tick();
        end
        start = 1'b0;
        check("gap_cnt_hold", cnt_val, 2);
        check("gap_still_load", in_ready, 1);
      end
      check("beat_index", cnt_val, i);
      in_valid = 1'b1;
      in_data  = d[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Called right after the last beat's edge; poke >0 pulses start at that latency
  task automatic wait_done(input int poke);
    exp_t e;
    int   lat = 1;
    bit   seen = 0;
    while (lat < 200) begin
      check("init_en_excl", cnt_init & cnt_en, 0);
      if (done) begin
        seen = 1;
        break;
      end
      start = (lat == poke);
      tick();
      start = 1'b0;
      lat++;
    end
    check("done_seen", seen, 1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        check("winner", winner, e.w);
        check("winner_val", winner_val, e.v);
        check("iter_count", iter_count, e.it);
        check("no_winner", no_winner, e.nw);
        check("timeout", timeout, e.to);
        check("latency", lat, e.lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("start_in_done_ignored", busy, 0);
        check("result_held", winner_val, e.v);
      end
    end
  endtask

  task automatic push(input logic [1:0] w, input logic [7:0] v, input logic [3:0] it,
                      input logic nw, input logic to, input int lat);
    exp_t e;
    e.w = w; e.v = v; e.it = it; e.nw = nw; e.to = to; e.lat = lat;
    sb.push_back(e);
  endtask

  initial begin
    int  lat;
    logic saw_done;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_winner", winner, 0);
    check("rst_winner_val", winner_val, 0);
    check("rst_iter", iter_count, 0);
    check("rst_no_winner", no_winner, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cnt_init", cnt_init, 1);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();

    // Four iterations to a single survivor
    push(2'd0, 8'd21, 4'd4, 1'b0, 1'b0, 38);
    start_run();
    load4(8'd40, 8'd30, 8'd20, 8'd10, 0);
    wait_done(0);

    // Already a single nonzero neuron
    push(2'd2, 8'd55, 4'd0, 1'b0, 1'b0, 2);
    start_run();
    load4(8'd0, 8'd0, 8'd55, 8'd0, 0);
    wait_done(0);

    // All zero
    push(2'd0, 8'd0, 4'd0, 1'b1, 1'b0, 2);
    start_run();
    load4(8'd0, 8'd0, 8'd0, 8'd0, 0);
    wait_done(0);

    // Tie never resolves: iteration limit
    push(2'd0, 8'd6, 4'd8, 1'b0, 1'b1, 74);
    start_run();
    load4(8'd50, 8'd50, 8'd0, 8'd0, 0);
    wait_done(0);

    // Stalled load beats and a start pulse while busy
    push(2'd0, 8'd21, 4'd4, 1'b0, 1'b0, 38);
    start_run();
    load4(8'd40, 8'd30, 8'd20, 8'd10, 3);
    wait_done(7);

    // Reset during the second iteration's update phase
    start_run();
    load4(8'd40, 8'd30, 8'd20, 8'd10, 0);
    for (lat = 1; lat < 16; lat++) tick();
    check("pre_abort_iter", iter_count, 1);
    check("pre_abort_busy", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_winner", winner, 0);
    check("abort_winner_val", winner_val, 0);
    check("abort_iter", iter_count, 0);
    check("abort_no_winner", no_winner, 0);
    check("abort_timeout", timeout, 0);
    check("abort_cnt_init", cnt_init, 1);
    check("abort_cnt_val", cnt_val, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      saw_done = saw_done | done;
    end
    check("abort_no_done", saw_done, 0);

    push(2'd0, 8'd21, 4'd4, 1'b0, 1'b0, 38);
    start_run();
    load4(8'd40, 8'd30, 8'd20, 8'd10, 0);
    wait_done(0);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
